// File: rtl/clkdiv_pkg.sv
// Shared types and helpers for the programmable clock divider family.
package clkdiv_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    // Smallest ratio that still produces a real output clock
    localparam int MIN_DIV = 2;

    // Number of source cycles the registered phase stays high: ceil(n/2)
    function automatic logic [31:0] half_count(input logic [31:0] n);
        return (n + 32'd1) >> 1;
    endfunction

endpackage

// File: rtl/clk_div_oddfix.sv
// Half-cycle retime stage that turns a ceil(N/2)-high phase into an exact
// 50% duty clock for odd ratios. Even ratios pass the posedge phase through.
module clk_div_oddfix (
    input  logic clk,
    input  logic reset,
    input  logic pos_q,
    input  logic odd_sel,
    output logic out
);

    logic neg_q;

    // Sample the posedge phase on the falling edge, delaying it by half a cycle
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= pos_q;
        end
    end

    // Odd: high only while both phases are high (trims half a cycle off the
    // front); even: the posedge phase alone. Only flop outputs feed this gate.
    assign out = pos_q & (neg_q | ~odd_sel);

endmodule

// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider, N = 2 .. 2^WIDTH-1.
// A new ratio is staged in a shadow register and only takes effect at a
// period boundary (or while idle), so every output period is complete.
module clk_div_prog
    import clkdiv_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] div_ratio,
    input  logic             load,
    output logic             out,
    output logic             period_tick,
    output logic             update_pending,
    output logic             ratio_err,
    output logic [WIDTH-1:0] active_div,
    inout  wire              VDD,
    inout  wire              VSS
);

    localparam logic [WIDTH-1:0] DEF_RATIO = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] MIN_RATIO = WIDTH'(MIN_DIV);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] cnt_reg, cnt_next;
    logic             pos_q, pos_next;
    logic [WIDTH-1:0] active_div_reg, active_div_next;
    logic [WIDTH-1:0] shadow_reg, shadow_next;
    logic             update_pending_reg, update_pending_next;
    logic             ratio_err_reg, ratio_err_next;

    logic [WIDTH-1:0] last_cnt;
    logic [WIDTH-1:0] half_next;
    logic [WIDTH-1:0] shadow_in;
    logic             ratio_clamped;
    logic             at_wrap;
    logic             apply_ratio;

    // Supply rails are carried for the netlist only; no logic depends on them
    wire unused_rails = VDD ^ VSS;

    assign last_cnt      = active_div_reg - WIDTH'(1);
    assign at_wrap       = (state_reg != IDLE) && (cnt_reg == last_cnt);
    assign ratio_clamped = (div_ratio < MIN_RATIO);
    assign shadow_in     = ratio_clamped ? MIN_RATIO : div_ratio;
    // A load in the same cycle supersedes the pending value and defers it
    assign apply_ratio   = update_pending_reg && !load &&
                           (at_wrap || (state_reg == IDLE));

    // Next-state, counter, phase and ratio-shadow logic
    always_comb begin
        state_next          = state_reg;
        cnt_next            = cnt_reg;
        active_div_next     = apply_ratio ? shadow_reg : active_div_reg;
        shadow_next         = load ? shadow_in : shadow_reg;
        update_pending_next = load ? 1'b1 : (apply_ratio ? 1'b0 : update_pending_reg);
        ratio_err_next      = ratio_err_reg | (load & ratio_clamped);

        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (enable) begin
                    state_next = RUN;
                end
            end
            RUN, STOPPING: begin
                cnt_next = at_wrap ? '0 : cnt_reg + WIDTH'(1);
                if (enable) begin
                    state_next = RUN;
                end else if (at_wrap) begin
                    state_next = IDLE;
                end else begin
                    state_next = STOPPING;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase

        // High phase length follows the ratio in force for the next count
        half_next = WIDTH'(half_count(32'(active_div_next)));
        pos_next  = (state_next != IDLE) && (cnt_next < half_next);
    end

    // State and datapath registers; reset drops the output immediately
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg          <= IDLE;
            cnt_reg            <= '0;
            pos_q              <= 1'b0;
            active_div_reg     <= DEF_RATIO;
            shadow_reg         <= DEF_RATIO;
            update_pending_reg <= 1'b0;
            ratio_err_reg      <= 1'b0;
        end else begin
            state_reg          <= state_next;
            cnt_reg            <= cnt_next;
            pos_q              <= pos_next;
            active_div_reg     <= active_div_next;
            shadow_reg         <= shadow_next;
            update_pending_reg <= update_pending_next;
            ratio_err_reg      <= ratio_err_next;
        end
    end

    // Odd/even select is the registered ratio LSB, so it only moves at a wrap
    clk_div_oddfix u_oddfix (
        .clk     (clk),
        .reset   (reset),
        .pos_q   (pos_q),
        .odd_sel (active_div_reg[0]),
        .out     (out)
    );

    assign period_tick    = at_wrap;
    assign update_pending = update_pending_reg;
    assign ratio_err      = ratio_err_reg;
    assign active_div     = active_div_reg;

endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
- Runtime-programmable integer clock divider. Divides clk by N, where N ranges over 2..2^WIDTH-1.
- Duty cycle is 50% for even N. For odd N, a negedge retime flop gives exact 50% duty, with no combinational clk term in the output path.
- The ratio updates glitch-free at period boundaries. Enable and stop are clean and never produce runt pulses.
- Drop-in successor to the fixed divide-by-9 in the clock divider tree; feeds downstream clock consumers.

Parameters:
- WIDTH, 8, width of the ratio and the internal counter.
- DEFAULT_DIV, 9, active ratio after reset; must lie in 2..2^WIDTH-1.

Ports:
- clk  input  1  source clock.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  run request, sampled on posedge clk.
- div_ratio  input  WIDTH  requested divide ratio N.
- load  input  1  single-cycle strobe; captures div_ratio into the shadow register.
- out  output  1  divided clock.
- period_tick  output  1  one-clk pulse on the last cycle of each output period.
- update_pending  output  1  shadow ratio captured but not yet applied.
- ratio_err  output  1  sticky flag; last load had div_ratio < 2 (clamped to 2).
- active_div  output  WIDTH  ratio currently in effect.
- VDD  inout  1  power.
- VSS  inout  1  ground.

Behaviour:
- Reset (reset=0, asynchronous):
  - cnt=0, pos_q=0, neg_q=0, out=0, period_tick=0.
  - active_div=DEFAULT_DIV, shadow=DEFAULT_DIV, update_pending=0, ratio_err=0, state=IDLE.
  - Reset asserted mid-operation forces out low immediately. No completion of the current period.
- Derived high count: H = ceil(N/2), with N = active_div.
- States:
  - IDLE: cnt=0, pos_q=0. If enable=1 at a posedge, go to RUN; cnt=0, pos_q=1. The first out rise follows that edge.
  - RUN:
    - cnt increments each posedge and wraps from N-1 to 0.
    - pos_q is registered: high when next cnt < H.
    - enable=0 at a posedge goes to STOPPING.
  - STOPPING:
    - Counting continues unchanged until the wrap.
    - At the wrap, go to IDLE with pos_q=0, so the last period is full length.
    - enable=1 during STOPPING returns to RUN with no disturbance to the output.
- neg_q samples pos_q on negedge clk.
- Output selection:
  - N even: out = pos_q. Out is high N/2 cycles and low N/2 cycles.
  - N odd: out = pos_q & neg_q. Out is high (N/2) cycles exactly; for N=9 that is 4.5 high and 4.5 low.
  - The odd/even select is registered from active_div, so it changes only at a wrap.
- period_tick is high in the cycle where cnt==N-1 (RUN or STOPPING).
- Ratio update:
  - load=1 captures the shadow: div_ratio, or 2 if div_ratio<2.
  - When clamped, set ratio_err (sticky until reset). Set update_pending=1.
  - On the next wrap (cnt N-1 to 0), or on the next posedge while in IDLE: active_div <= shadow and update_pending clears.
  - load coinciding with the wrap cycle: the new value is captured and applied at the following wrap. The previously pending value is discarded.
  - Multiple loads before a wrap: the last one wins.
- Counter width is WIDTH. With N ≤ 2^WIDTH-1, cnt never overflows.
- Output is glitch-free across ratio changes and enable changes. Every out period is a complete period of either the old or the new ratio.

Decomposition:
- Shared package clkdiv_pkg holds:
  - the state enum (IDLE, RUN, STOPPING);
  - MIN_DIV=2;
  - the function half_count(N) = (N+1)>>1.
- One sub-module, clk_div_oddfix: the negedge retime flop plus the odd/even output AND-mux. It is reusable by other dividers.

Test Plan:
- Reset released, enable=1, no load: out period is 9 clk with 4.5 clk high (edges on negedge); period_tick every 9 cycles; active_div=9.
- load div_ratio=4 mid-period: update_pending=1 until the wrap; the current 9-period completes; subsequent out is 2 high / 2 low; active_div=4.
- load div_ratio=1: ratio_err=1 and active_div=2 after the wrap; out toggles every clk; ratio_err holds until reset.
- enable dropped at cnt=3 with N=7: the period runs to cnt=6, then out stays 0 in IDLE; re-enable restarts with out rising after the first posedge.
- reset pulled low at cnt=2 with out high: out=0 immediately (asynchronous); after release, active_div=9 and update_pending=0.
- Back-to-back loads 5 then 6 within one period: only 6 is applied at the wrap; out is 3 high / 3 low.
